// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared CPU widths and write-back requester identifiers.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // Requester ids double as bit positions in the arbiter request/grant vectors
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_rr_arb.sv
// +--------------------------------------------------------------------------+
// | wb_rr_arb : two-input round-robin arbiter with a one-bit priority pointer.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_rr_arb
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e prio;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio == WB_LSU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Only a contested grant moves the pointer, and it always moves to the loser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= WB_ALU;
    end else if (req == 2'b11) begin
      prio <= (prio == WB_ALU) ? WB_LSU : WB_ALU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
// +--------------------------------------------------------------------------+
// | regfile_wb_ctrl : ALU/LSU write-back arbitration, write stage and RAW     |
// | scoreboard. Optional macro WB_BYPASS_EN adds write-stage bypass ports.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_ctrl #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            RegW,
  output logic [AW-1:0]   Rd,
  output logic [XLEN-1:0] Wd
`ifdef WB_BYPASS_EN
  ,
  output logic            byp1_en,
  output logic            byp2_en,
  output logic [XLEN-1:0] byp_wd
`endif
);

  import cpu_pkg::*;

  localparam logic [NREG-1:0] WRITABLE_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            grant_any;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_wd;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_set;
  logic [NREG-1:0] pending_clr;
  logic            wr_hit1;
  logic            wr_hit2;

  assign req[WB_ALU] = alu_valid;
  assign req[WB_LSU] = lsu_valid;

  wb_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[WB_ALU];
  assign lsu_ready = gnt[WB_LSU];
  assign grant_any = |gnt;
  assign gnt_rd    = gnt[WB_LSU] ? lsu_rd : alu_rd;
  assign gnt_wd    = gnt[WB_LSU] ? lsu_wd : alu_wd;

  // x0 grants still load Rd/Wd but never raise RegW
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegW <= 1'b0;
      Rd   <= '0;
      Wd   <= '0;
    end else if (grant_any) begin
      RegW <= (gnt_rd != '0);
      Rd   <= gnt_rd;
      Wd   <= gnt_wd;
    end else begin
      RegW <= 1'b0;
    end
  end

  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (iss_valid && (iss_rd != '0)) begin
      pending_set[iss_rd] = 1'b1;
    end
    if (grant_any && (gnt_rd != '0)) begin
      pending_clr[gnt_rd] = 1'b1;
    end
  end

  // Set is applied after clear so a same-index issue survives the write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~pending_clr) | pending_set) & WRITABLE_MASK;
    end
  end

  assign wr_hit1 = RegW && (Rd == rs1);
  assign wr_hit2 = RegW && (Rd == rs2);

`ifdef WB_BYPASS_EN
  assign busy_rs1 = pending[rs1];
  assign busy_rs2 = pending[rs2];
  assign byp1_en  = wr_hit1 && (rs1 != '0);
  assign byp2_en  = wr_hit2 && (rs2 != '0);
  assign byp_wd   = Wd;
`else
  // Without bypass, hold issue off until the register file has taken the write
  assign busy_rs1 = pending[rs1] | wr_hit1;
  assign busy_rs2 = pending[rs2] | wr_hit2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_ctrl : directed self-checking bench for regfile_wb_ctrl.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        RegW;
  logic [4:0]  Rd;
  logic [31:0] Wd;
`ifdef WB_BYPASS_EN
  logic        byp1_en;
  logic        byp2_en;
  logic [31:0] byp_wd;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_pend;
  logic [31:0] tb_pend_nxt;

  regfile_wb_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_wd    (lsu_wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
    .RegW      (RegW),
    .Rd        (Rd),
    .Wd        (Wd)
`ifdef WB_BYPASS_EN
    ,
    .byp1_en   (byp1_en),
    .byp2_en   (byp2_en),
    .byp_wd    (byp_wd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent pending model used to flag illegal re-issue to a pending rd
  always_comb begin
    tb_pend_nxt = tb_pend;
    if (alu_valid && alu_ready) tb_pend_nxt[alu_rd] = 1'b0;
    if (lsu_valid && lsu_ready) tb_pend_nxt[lsu_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) tb_pend_nxt[iss_rd] = 1'b1;
    tb_pend_nxt[0] = 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tb_pend <= '0;
    end else begin
      if (iss_valid && (iss_rd != 5'd0)) begin
        checks++;
        assert (!tb_pend[iss_rd]) else begin
          errors++;
          $error("FAIL reissue: observed pending=1 for x%0d expected 0", iss_rd);
        end
      end
      tb_pend <= tb_pend_nxt;
    end
  end

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1 = '0; rs2 = '0;

    // Reset state and ready behaviour while held in reset
    #1;
    check("rst_regw", {31'd0, RegW}, 32'd0);
    check("rst_rd", {27'd0, Rd}, 32'd0);
    check("rst_wd", Wd, 32'd0);
    check("rst_busy1", {31'd0, busy_rs1}, 32'd0);
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single ALU write x5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    #1;
    check("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("t1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    check("t1_regw", {31'd0, RegW}, 32'd1);
    check("t1_rd", {27'd0, Rd}, 32'd5);
    check("t1_wd", Wd, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t1_regw_drop", {31'd0, RegW}, 32'd0);
    check("t1_rd_hold", {27'd0, Rd}, 32'd5);

    // Contested stream: ALU, LSU, ALU, LSU
    alu_valid = 1'b1; alu_rd = 5'd1;  alu_wd = 32'hA000_0001;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wd = 32'hB000_000B;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_alu_ready", {31'd0, alu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_lsu_ready", {31'd0, lsu_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      check("t2_regw", {31'd0, RegW}, 32'd1);
      if (k % 2 == 0) begin
        check("t2_rd", {27'd0, Rd}, 32'(1 + k / 2));
        check("t2_wd", Wd, 32'hA000_0000 | 32'(1 + k / 2));
        alu_rd = alu_rd + 5'd1; alu_wd = 32'hA000_0000 | {27'd0, alu_rd};
      end else begin
        check("t2_rd", {27'd0, Rd}, 32'(11 + k / 2));
        check("t2_wd", Wd, 32'hB000_0000 | 32'(11 + k / 2));
        lsu_rd = lsu_rd + 5'd1; lsu_wd = 32'hB000_0000 | {27'd0, lsu_rd};
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(posedge clk); #1;
    check("t2_idle_regw", {31'd0, RegW}, 32'd0);

    // Issue x7, then LSU writes x7
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    #1;
    check("t3_busy_pre", {31'd0, busy_rs1}, 32'd0);
    @(posedge clk); #1;
    iss_valid = 1'b0;
    #1;
    check("t3_busy_set", {31'd0, busy_rs1}, 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h12;
    #1;
    check("t3_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    check("t3_regw", {31'd0, RegW}, 32'd1);
    check("t3_rd", {27'd0, Rd}, 32'd7);
    check("t3_wd", Wd, 32'h12);
`ifdef WB_BYPASS_EN
    check("t3_busy_wr", {31'd0, busy_rs1}, 32'd0);
    check("t3_byp1_en", {31'd0, byp1_en}, 32'd1);
    check("t3_byp_wd", byp_wd, 32'h12);
`else
    check("t3_busy_wr", {31'd0, busy_rs1}, 32'd1);
`endif
    @(posedge clk); #1;
    check("t3_busy_clr", {31'd0, busy_rs1}, 32'd0);
    check("t3_regw_drop", {31'd0, RegW}, 32'd0);

    // Same-cycle issue and write-back of x9: set wins
    iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
    @(posedge clk); #1;
    iss_valid = 1'b0; alu_valid = 1'b0;
    check("t4_regw", {31'd0, RegW}, 32'd1);
    check("t4_rd", {27'd0, Rd}, 32'd9);
    check("t4_busy", {31'd0, busy_rs2}, 32'd1);
    @(posedge clk); #1;
    check("t4_regw_drop", {31'd0, RegW}, 32'd0);
    check("t4_busy_kept", {31'd0, busy_rs2}, 32'd1);

    // Write-back and issue targeting x0
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    #1;
    check("t5_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("t5_busy_pre", {31'd0, busy_rs1}, 32'd0);
    @(posedge clk); #1;
    lsu_valid = 1'b0; iss_valid = 1'b0;
    check("t5_regw", {31'd0, RegW}, 32'd0);
    check("t5_rd", {27'd0, Rd}, 32'd0);
    check("t5_wd", Wd, 32'hFFFF);
    check("t5_busy", {31'd0, busy_rs1}, 32'd0);

    // Asynchronous reset while the write stage holds a live write
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33; rs1 = 5'd3;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    check("t6_regw_live", {31'd0, RegW}, 32'd1);
    check("t6_busy2_live", {31'd0, busy_rs2}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_regw_rst", {31'd0, RegW}, 32'd0);
    check("t6_rd_rst", {27'd0, Rd}, 32'd0);
    check("t6_wd_rst", Wd, 32'd0);
    check("t6_busy1_rst", {31'd0, busy_rs1}, 32'd0);
    check("t6_busy2_rst", {31'd0, busy_rs2}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_busy2_after", {31'd0, busy_rs2}, 32'd0);
    check("t6_regw_after", {31'd0, RegW}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
